// File: rtl/bcd_sched_pkg.sv
// ----------------------------------------------------------------------------
// bcd_sched_pkg
// Shared definitions for the BCD converter scheduler:
//   - scheduler FSM state encoding
//   - sample width, BCD saturation limit and converter minimum latency
//   - clamp_sample(): two's-complement sample -> {sign, ovf, 4-digit magnitude}
// ----------------------------------------------------------------------------
package bcd_sched_pkg;

    localparam int              SAMPLE_W         = 16;
    localparam logic [15:0]     BCD_MAX          = 16'd9999;
    localparam int              CONV_LATENCY_MIN = 36;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_START   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_CAPTURE = 2'd3
    } state_t;

    typedef struct packed {
        logic                sign;
        logic                ovf;
        logic [SAMPLE_W-1:0] bin;
    } clamp_t;

    // The magnitude is formed 17 bits wide so that -32768 maps to +32768
    // instead of wrapping back to a negative value.
    function automatic clamp_t clamp_sample(input logic [SAMPLE_W-1:0] sample);
        clamp_t          res;
        logic [SAMPLE_W:0] mag;
        if (sample[SAMPLE_W-1]) begin
            mag = 17'd0 - {1'b1, sample};
        end else begin
            mag = {1'b0, sample};
        end
        res.sign = sample[SAMPLE_W-1];
        if (mag > {1'b0, BCD_MAX}) begin
            res.ovf = 1'b1;
            res.bin = BCD_MAX;
        end else begin
            res.ovf = 1'b0;
            res.bin = mag[SAMPLE_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/bcd_conv_scheduler_if.sv
// ----------------------------------------------------------------------------
// bcd_conv_scheduler_if
// Sample-side bundle of the BCD converter scheduler.
//   req      per-channel conversion request
//   din      per-channel signed samples, channel i at [16i+15:16i]
//   busy     scheduler is not idle
//   bcd_data per-channel 4-digit BCD result
//   sign     per-channel sign of the converted sample (1 = negative)
//   ovf      per-channel saturation flag (magnitude clamped to 9999)
//   done     one-cycle pulse when a channel's result updates
// master: sample source / display side.  slave: the scheduler.
// ----------------------------------------------------------------------------
interface bcd_conv_scheduler_if #(
    parameter int N_CH = 3
);
    logic [N_CH-1:0]      req;
    logic [16*N_CH-1:0]   din;
    logic                 busy;
    logic [16*N_CH-1:0]   bcd_data;
    logic [N_CH-1:0]      sign;
    logic [N_CH-1:0]      ovf;
    logic [N_CH-1:0]      done;

    modport master (
        output req, din,
        input  busy, bcd_data, sign, ovf, done
    );

    modport slave (
        input  req, din,
        output busy, bcd_data, sign, ovf, done
    );
endinterface

// File: rtl/bcd_sched_rr_arbiter.sv
// ----------------------------------------------------------------------------
// bcd_sched_rr_arbiter
// Combinational round-robin picker: grants the first pending channel at or
// after rr_ptr, wrapping modulo N_CH.
//   pending     in  N_CH   pending request vector
//   rr_ptr      in  IDX_W  highest-priority index for this pick
//   grant       out N_CH   one-hot grant (zero when nothing pending)
//   grant_idx   out IDX_W  binary index of the granted channel
//   any_pending out 1      at least one pending bit set
// ----------------------------------------------------------------------------
module bcd_sched_rr_arbiter #(
    parameter int N_CH = 3
) (
    input  logic [N_CH-1:0]         pending,
    input  logic [$clog2(N_CH)-1:0] rr_ptr,
    output logic [N_CH-1:0]         grant,
    output logic [$clog2(N_CH)-1:0] grant_idx,
    output logic                    any_pending
);
    localparam int IDX_W = $clog2(N_CH);

    logic [N_CH-1:0]  grant_s;
    logic [IDX_W-1:0] idx_s;
    logic             found_s;
    int               sum_s;
    logic [IDX_W-1:0] cand_s;

    // Scan from rr_ptr upward with wrap; the first pending candidate wins.
    always_comb begin
        grant_s = '0;
        idx_s   = '0;
        found_s = 1'b0;
        sum_s   = 0;
        cand_s  = '0;
        for (int k = 0; k < N_CH; k++) begin
            sum_s  = int'(rr_ptr) + k;
            cand_s = (sum_s >= N_CH) ? IDX_W'(sum_s - N_CH) : IDX_W'(sum_s);
            if (!found_s && pending[cand_s]) begin
                found_s         = 1'b1;
                grant_s[cand_s] = 1'b1;
                idx_s           = cand_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    assign grant       = grant_s;
    assign grant_idx   = idx_s;
    assign any_pending = |pending;

endmodule

// File: rtl/bcd_conv_scheduler.sv
// ----------------------------------------------------------------------------
// bcd_conv_scheduler
// Time-shares one external 16-bit binary-to-BCD converter among N_CH signed
// sample channels. Requests are latched as pending bits with a snapshot of
// the sample; channels are served round-robin. The selected sample is clamped
// to a 4-digit magnitude, the converter is started, and after CONV_LATENCY
// cycles its BCD output is latched into that channel's result register.
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   srst       in   synchronous soft reset (same effect as rst_n)
//   bus        slave sample/result bundle (req, din, busy, bcd_data, sign,
//              ovf, done)
//   conv_rst   out  active-high converter reset (async assert, 2-flop release)
//   conv_start out  converter START, one cycle
//   conv_bin   out  clamped magnitude presented to the converter
//   conv_bcd   in   converter BCD output
// ----------------------------------------------------------------------------
module bcd_conv_scheduler
    import bcd_sched_pkg::*;
#(
    parameter int N_CH         = 3,
    parameter int CONV_LATENCY = 36
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 srst,
    bcd_conv_scheduler_if.slave  bus,
    output logic                 conv_rst,
    output logic                 conv_start,
    output logic [SAMPLE_W-1:0]  conv_bin,
    input  logic [SAMPLE_W-1:0]  conv_bcd
);
    localparam int IDX_W = $clog2(N_CH);

    if (CONV_LATENCY < CONV_LATENCY_MIN) begin : g_lat_chk
        $error("bcd_conv_scheduler: CONV_LATENCY is below the converter minimum");
    end
    if ((N_CH < 2) || (N_CH > 8)) begin : g_nch_chk
        $error("bcd_conv_scheduler: N_CH must be within 2..8");
    end

    // Request capture
    logic [N_CH-1:0]                pending_r;
    logic [N_CH-1:0][SAMPLE_W-1:0]  snap_r;
    logic [N_CH-1:0]                clr_s;

    // Arbitration
    logic [N_CH-1:0]                grant_s;
    logic [IDX_W-1:0]               idx_s;
    logic                           any_s;
    clamp_t                         clamp_s;

    // FSM and registered outputs
    state_t                         state_r;
    logic [IDX_W-1:0]               rr_ptr_r;
    logic [IDX_W-1:0]               sel_r;
    logic [15:0]                    cnt_r;
    logic                           hold_sign_r;
    logic                           hold_ovf_r;
    logic                           busy_r;
    logic                           conv_start_r;
    logic [SAMPLE_W-1:0]            conv_bin_r;
    logic [N_CH-1:0][SAMPLE_W-1:0]  bcd_data_r;
    logic [N_CH-1:0]                sign_r;
    logic [N_CH-1:0]                ovf_r;
    logic [N_CH-1:0]                done_r;
    logic [1:0]                     conv_rst_sync_r;

    bcd_sched_rr_arbiter #(
        .N_CH (N_CH)
    ) u_arb (
        .pending     (pending_r),
        .rr_ptr      (rr_ptr_r),
        .grant       (grant_s),
        .grant_idx   (idx_s),
        .any_pending (any_s)
    );

    assign clamp_s = clamp_sample(snap_r[idx_s]);

    // Pending bit of the granted channel is consumed when IDLE launches it.
    always_comb begin
        clr_s = '0;
        if ((state_r == ST_IDLE) && any_s) begin
            clr_s = grant_s;
        end else begin
            clr_s = '0;
        end
    end

    // Pending bits and snapshots; a same-cycle REQ beats the IDLE clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_r <= '0;
            snap_r    <= '0;
        end else if (srst) begin
            pending_r <= '0;
            snap_r    <= '0;
        end else begin
            pending_r <= (pending_r & ~clr_s) | bus.req;
            for (int i = 0; i < N_CH; i++) begin
                if (bus.req[i]) begin
                    snap_r[i] <= bus.din[i*SAMPLE_W +: SAMPLE_W];
                end else begin
                    snap_r[i] <= snap_r[i];
                end
            end
        end
    end

    // Converter reset: asserted with reset, released on the 2nd clean edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conv_rst_sync_r <= 2'b11;
        end else if (srst) begin
            conv_rst_sync_r <= 2'b11;
        end else begin
            conv_rst_sync_r <= {conv_rst_sync_r[0], 1'b0};
        end
    end

    // Scheduler FSM with all of its outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            rr_ptr_r     <= '0;
            sel_r        <= '0;
            cnt_r        <= 16'd0;
            hold_sign_r  <= 1'b0;
            hold_ovf_r   <= 1'b0;
            busy_r       <= 1'b0;
            conv_start_r <= 1'b0;
            conv_bin_r   <= '0;
            bcd_data_r   <= '0;
            sign_r       <= '0;
            ovf_r        <= '0;
            done_r       <= '0;
        end else if (srst) begin
            state_r      <= ST_IDLE;
            rr_ptr_r     <= '0;
            sel_r        <= '0;
            cnt_r        <= 16'd0;
            hold_sign_r  <= 1'b0;
            hold_ovf_r   <= 1'b0;
            busy_r       <= 1'b0;
            conv_start_r <= 1'b0;
            conv_bin_r   <= '0;
            bcd_data_r   <= '0;
            sign_r       <= '0;
            ovf_r        <= '0;
            done_r       <= '0;
        end else begin
            done_r       <= '0;
            conv_start_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (any_s) begin
                        sel_r        <= idx_s;
                        conv_bin_r   <= clamp_s.bin;
                        hold_sign_r  <= clamp_s.sign;
                        hold_ovf_r   <= clamp_s.ovf;
                        conv_start_r <= 1'b1;
                        busy_r       <= 1'b1;
                        state_r      <= ST_START;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_START: begin
                    // WAIT spans CONV_LATENCY-1 cycles: counts N-2 down to 0.
                    cnt_r   <= 16'(CONV_LATENCY - 2);
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (cnt_r == 16'd0) begin
                        state_r <= ST_CAPTURE;
                    end else begin
                        cnt_r <= cnt_r - 16'd1;
                    end
                end
                ST_CAPTURE: begin
                    bcd_data_r[sel_r] <= conv_bcd;
                    sign_r[sel_r]     <= hold_sign_r;
                    ovf_r[sel_r]      <= hold_ovf_r;
                    done_r[sel_r]     <= 1'b1;
                    if (sel_r == IDX_W'(N_CH - 1)) begin
                        rr_ptr_r <= '0;
                    end else begin
                        rr_ptr_r <= sel_r + IDX_W'(1);
                    end
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = busy_r;
    assign bus.bcd_data = bcd_data_r;
    assign bus.sign     = sign_r;
    assign bus.ovf      = ovf_r;
    assign bus.done     = done_r;
    assign conv_rst     = conv_rst_sync_r[1];
    assign conv_start   = conv_start_r;
    assign conv_bin     = conv_bin_r;

endmodule

// File: tb/tb_bcd_conv_scheduler.sv
// ----------------------------------------------------------------------------
// tb_bcd_conv_scheduler
// Directed bench for bcd_conv_scheduler with a behavioural converter model
// (BCDOUT updates 35 edges after START is sampled, shows 16'hEEEE meanwhile).
// Stimulus pushes hand-computed expected results into a queue; a monitor pops
// one entry per DONE pulse and compares the full result vectors against a
// shadow copy, plus the DONE cycle.
// ----------------------------------------------------------------------------
module tb_bcd_conv_scheduler;
    localparam int N_CH = 3;
    localparam int LAT  = 36;

    logic        clk;
    logic        rst_n;
    logic        srst;
    logic        conv_rst;
    logic        conv_start;
    logic [15:0] conv_bin;
    logic [15:0] conv_bcd;

    bcd_conv_scheduler_if #(.N_CH(N_CH)) bus ();

    bcd_conv_scheduler #(
        .N_CH         (N_CH),
        .CONV_LATENCY (LAT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .srst       (srst),
        .bus        (bus),
        .conv_rst   (conv_rst),
        .conv_start (conv_start),
        .conv_bin   (conv_bin),
        .conv_bcd   (conv_bcd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural converter
    int          cv_cnt;
    logic [15:0] cv_hold;

    function automatic logic [15:0] to_bcd(input logic [15:0] b);
        int v;
        v = int'(b);
        return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    always @(posedge clk or posedge conv_rst) begin
        if (conv_rst) begin
            cv_cnt   <= 0;
            cv_hold  <= 16'h0000;
            conv_bcd <= 16'h0000;
        end else if (conv_start) begin
            cv_cnt   <= 35;
            cv_hold  <= conv_bin;
            conv_bcd <= 16'hEEEE;
        end else if (cv_cnt > 0) begin
            cv_cnt <= cv_cnt - 1;
            if (cv_cnt == 1) conv_bcd <= to_bcd(cv_hold);
        end
    end

    // Scoreboard
    typedef struct {
        int          ch;
        logic [15:0] bcd;
        logic        sgn;
        logic        ov;
        int          cyc;
    } exp_t;

    exp_t                     exp_q[$];
    logic [N_CH-1:0][15:0]    sh_bcd;
    logic [N_CH-1:0]          sh_sign;
    logic [N_CH-1:0]          sh_ovf;
    int                       n_checks = 0;
    int                       n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, want, cyc);
    endtask

    task automatic push(input int ch, input logic [15:0] bcd, input logic s, input logic o, input int c);
        exp_t e;
        e.ch  = ch;
        e.bcd = bcd;
        e.sgn = s;
        e.ov  = o;
        e.cyc = c;
        exp_q.push_back(e);
    endtask

    // Monitor: one queue entry per DONE pulse.
    initial begin
        exp_t            e;
        logic [N_CH-1:0] oh;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && bus.done !== '0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 64'(bus.done), 64'd0);
                end else begin
                    e  = exp_q.pop_front();
                    oh = '0;
                    oh[e.ch] = 1'b1;
                    sh_bcd[e.ch]  = e.bcd;
                    sh_sign[e.ch] = e.sgn;
                    sh_ovf[e.ch]  = e.ov;
                    check($sformatf("done_ch%0d", e.ch), 64'(bus.done), 64'(oh));
                    check($sformatf("bcd_data_ch%0d", e.ch), 64'(bus.bcd_data), 64'(sh_bcd));
                    check($sformatf("sign_ch%0d", e.ch), 64'(bus.sign), 64'(sh_sign));
                    check($sformatf("ovf_ch%0d", e.ch), 64'(bus.ovf), 64'(sh_ovf));
                    check($sformatf("done_cycle_ch%0d", e.ch), 64'(cyc), 64'(e.cyc));
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic req_one(input int ch, input logic [15:0] val);
        bus.din[ch*16 +: 16] = val;
        bus.req[ch] = 1'b1;
        tick(1);
        bus.req = '0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        #1;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else begin
            $display("FAIL %s: %0d expected results missing, required 0", name, exp_q.size());
            exp_q.delete();
        end
        tick(2);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},       64'(bus.busy),     64'd0);
        check({tag, "_bcd_data"},   64'(bus.bcd_data), 64'd0);
        check({tag, "_sign"},       64'(bus.sign),     64'd0);
        check({tag, "_ovf"},        64'(bus.ovf),      64'd0);
        check({tag, "_done"},       64'(bus.done),     64'd0);
        check({tag, "_conv_start"}, 64'(conv_start),   64'd0);
        check({tag, "_conv_bin"},   64'(conv_bin),     64'd0);
        check({tag, "_conv_rst"},   64'(conv_rst),     64'd1);
    endtask

    int c0;

    initial begin
        rst_n   = 1'b0;
        srst    = 1'b0;
        bus.req = '0;
        bus.din = '0;
        sh_bcd  = '0;
        sh_sign = '0;
        sh_ovf  = '0;

        tick(3);
        check_reset_outputs("por");
        rst_n = 1'b1;
        tick(1);
        check("conv_rst_edge1", 64'(conv_rst), 64'd1);
        tick(1);
        check("conv_rst_edge2", 64'(conv_rst), 64'd0);
        tick(2);

        // Single conversion, latency 39 cycles from REQ
        c0 = cyc; push(0, 16'h1234, 1'b0, 1'b0, c0 + 39); req_one(0, 16'd1234); drain("t_pos");
        // Negative and zero on channel 1
        c0 = cyc; push(1, 16'h0567, 1'b1, 1'b0, c0 + 39); req_one(1, 16'hFDC9); drain("t_neg");
        c0 = cyc; push(1, 16'h0000, 1'b0, 1'b0, c0 + 39); req_one(1, 16'h0000); drain("t_zero");
        // Clamping boundaries; ends with rr_ptr back at 0
        c0 = cyc; push(0, 16'h9999, 1'b0, 1'b1, c0 + 39); req_one(0, 16'd12000); drain("t_clamp_pos");
        c0 = cyc; push(1, 16'h9999, 1'b0, 1'b0, c0 + 39); req_one(1, 16'd9999);  drain("t_9999");
        c0 = cyc; push(2, 16'h9999, 1'b1, 1'b1, c0 + 39); req_one(2, 16'h8000);  drain("t_min");

        // All three at once: order 0,1,2 spaced 38 cycles
        c0 = cyc;
        push(0, 16'h0100, 1'b0, 1'b0, c0 + 39);
        push(1, 16'h2500, 1'b1, 1'b0, c0 + 77);
        push(2, 16'h4321, 1'b0, 1'b0, c0 + 115);
        bus.din = {16'h10E1, 16'hF63C, 16'h0064};
        bus.req = 3'b111;
        tick(1);
        bus.req = '0;
        drain("t_all");

        // Fairness: after ch1, ch2 goes before ch0
        c0 = cyc; push(1, 16'h0042, 1'b0, 1'b0, c0 + 39); req_one(1, 16'd42);
        tick(9);
        push(2, 16'h3000, 1'b0, 1'b0, c0 + 77);
        push(0, 16'h0007, 1'b0, 1'b0, c0 + 115);
        bus.din = {16'd3000, 16'd42, 16'd7};
        bus.req = 3'b101;
        tick(1);
        bus.req = '0;
        drain("t_fair");

        // Re-request during own WAIT produces a second conversion with new data
        c0 = cyc; push(0, 16'h0111, 1'b0, 1'b0, c0 + 39); req_one(0, 16'd111);
        tick(9);
        push(0, 16'h0222, 1'b0, 1'b0, c0 + 77); req_one(0, 16'd222);
        drain("t_rereq");

        // Reset during WAIT aborts the conversion without a DONE
        req_one(2, 16'd777);
        tick(14);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort_now");
        tick(3);
        check_reset_outputs("abort_held");
        sh_bcd  = '0;
        sh_sign = '0;
        sh_ovf  = '0;
        rst_n = 1'b1;
        tick(60);
        check("abort_busy_idle", 64'(bus.busy), 64'd0);
        check("abort_bcd_clear", 64'(bus.bcd_data), 64'd0);
        c0 = cyc; push(2, 16'h0777, 1'b0, 1'b0, c0 + 39); req_one(2, 16'd777); drain("t_after_rst");

        tick(5);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bcd_conv_scheduler.md
# bcd_conv_scheduler

Time-shares one 16-bit binary-to-BCD converter among N_CH signed sample sources, e.g. gyro X/Y/Z. Each channel's conversion requests are queued, and channels are granted in round-robin order. For the granted channel the block clamps the two's-complement value to a 4-digit magnitude, pulses the converter's START, waits the converter's fixed latency, and latches its BCDOUT into that channel's result register. It sits between the sensor sample registers and the seven-segment/UART display logic.

## Interface
- N_CH, 3: number of requesting channels (2..8).
- CONV_LATENCY, 36: cycles from the START-high cycle to the BCD capture cycle. Minimum 36. The converter updates BCDOUT 35 edges after sampling START.
- CLK  in  1  system clock, 100 MHz.
- RST  in  1  reset, asynchronous, active-low.
- REQ  in  N_CH  per-channel conversion request. Sampled each cycle.
- DIN  in  16*N_CH  signed two's-complement samples. Channel i is DIN[16i+15:16i].
- BUSY  out  1  high whenever the state is not IDLE.
- BCD_DATA  out  16*N_CH  per-channel 4-digit BCD result.
- SIGN  out  N_CH  per-channel sign of the converted sample. 1 means negative.
- OVF  out  N_CH  per-channel flag: the magnitude was clamped to 9999.
- DONE  out  N_CH  one-cycle pulse when channel i's result updates.
- CONV_RST  out  1  active-high reset to the converter.
- CONV_START  out  1  converter START.
- CONV_BIN  out  16  converter BIN.
- CONV_BCD  in  16  converter BCDOUT.

## Operation
- Reset values:
  - All outputs are 0, including BCD_DATA, SIGN, OVF, DONE, BUSY, CONV_START and CONV_BIN.
  - CONV_RST is 1.
  - Pending bits and snapshots are 0, the round-robin pointer is 0, and the state is IDLE.
- CONV_RST is asserted asynchronously with RST. It deasserts synchronously on the 2nd CLK edge after RST releases, through a 2-flop synchronizer.
- Request capture, per channel:
  - REQ[i]=1 sets pending[i] and loads snap[i] <= DIN[i].
  - If REQ[i] is high while channel i is already pending, the snapshot is overwritten and the latest value wins.
  - A REQ for the channel currently in conversion creates a new pending entry. It does not disturb the running conversion.
- FSM states: IDLE, START, WAIT, CAPTURE.
  - IDLE:
    - With any pending bit set, select a channel: the first pending index at or after rr_ptr, wrapping modulo N_CH.
    - Clear pending[sel]. If REQ[sel] is high in the same cycle, the set wins and carries the new snapshot.
    - Register the clamped magnitude onto CONV_BIN and the sign/ovf into holding registers.
    - Go to START.
  - START: CONV_START=1 for exactly this cycle. Load the wait counter with CONV_LATENCY-2 and go to WAIT.
  - WAIT: decrement the counter and go to CAPTURE when it is 0.
  - CAPTURE:
    - BCD_DATA[sel] <= CONV_BCD, SIGN[sel] <= hold_sign, OVF[sel] <= hold_ovf.
    - DONE[sel] is high in the following cycle.
    - rr_ptr <= (sel+1) mod N_CH.
    - Go to IDLE.
- Clamping:
  - mag = DIN[15] ? -DIN : DIN, computed 17-bit so that -32768 gives 32768.
  - If mag > 9999, CONV_BIN = 9999 and ovf=1; otherwise CONV_BIN = mag[15:0] and ovf=0.
  - sign = DIN[15]. Zero has sign 0.
- CONV_BIN is held constant from IDLE exit through CAPTURE.
- BCD_DATA, SIGN and OVF of non-selected channels never change.
- RST low mid-conversion aborts everything. Pending requests are discarded, and the converter is reset via CONV_RST.

## Timing
- REQ high in cycle c0, block idle:
  - pending is set at the end of c0.
  - IDLE selects in c1.
  - START in c2.
  - CAPTURE in c2+CONV_LATENCY.
  - DONE high in c3+CONV_LATENCY, which is c39 for the default.
- Throughput: one conversion per CONV_LATENCY+2 cycles, 38 by default. Back-to-back DONE pulses are 38 cycles apart.
- BUSY is high from c2 through the CAPTURE cycle.
- Worst-case wait for a pending channel is N_CH conversions.
- The converter is back in its Idle before the next START. START to its Idle takes 36 edges, and the next START is 38 cycles later.

## Structure
- Package bcd_sched_pkg holds:
  - the state enum (IDLE, START, WAIT, CAPTURE);
  - BCD_MAX = 16'd9999;
  - CONV_LATENCY_MIN = 36;
  - the sample width of 16.
- Sub-module bcd_sched_rr_arbiter: combinational round-robin pick from the pending vector and rr_ptr. Outputs are a one-hot grant, a binary index, and any_pending.
- The converter is instantiated by the parent and wired to CONV_* ports.
- Elaboration check: CONV_LATENCY >= CONV_LATENCY_MIN.

## Test plan
- Channel 0, DIN=1234, single REQ pulse -> BCD_DATA[0]=16'h1234, SIGN[0]=0, OVF[0]=0. DONE[0] is high exactly 39 cycles after the REQ cycle.
- Channel 1, DIN=-567 (16'hFDC9) -> BCD_DATA[1]=16'h0567, SIGN=1, OVF=0. Also DIN=0 -> 16'h0000, SIGN=0.
- Clamping:
  - DIN=12000 -> 16'h9999, OVF=1, SIGN=0.
  - DIN=-32768 -> 16'h9999, OVF=1, SIGN=1.
  - DIN=9999 -> 16'h9999, OVF=0.
- REQ=3'b111 in one cycle with distinct data -> channel order 0, 1, 2, DONE pulses 38 cycles apart, and each result lands only in its own channel.
- Fairness:
  - After channel 1 is served, with channels 0 and 2 pending -> channel 2 is served before channel 0.
  - REQ[0] re-asserted with a new value during channel 0's WAIT -> a second conversion carries the new value.
- RST low for 3 cycles during WAIT:
  - All outputs return to reset values and CONV_RST=1.
  - No DONE is produced for the aborted conversion.
  - A REQ issued after release completes normally with the correct BCD.
